// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter with a registered grant FSM, bus req/ack handshake and timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build gives the data port fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ireq_i,
  input  logic [ADDR_W-1:0]   iaddr_i,
  output logic                iack_o,
  output logic [DATA_W-1:0]   idata_o,
  output logic                ierr_o,
  input  logic                dreq_i,
  input  logic                dwe_i,
  input  logic [ADDR_W-1:0]   daddr_i,
  input  logic [DATA_W-1:0]   dwdata_i,
  input  logic [DATA_W/8-1:0] dsel_i,
  output logic                dack_o,
  output logic [DATA_W-1:0]   ddata_o,
  output logic                derr_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t            state, state_n;
  logic [7:0]        cnt;
  logic              any_req, pick_d, in_grant, finish;
  logic              bus_req_n, bus_we_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [DATA_W-1:0] bus_wdata_n;
  logic [SEL_W-1:0]  bus_sel_n;
  logic              iack_n, ierr_n, dack_n, derr_n;
  logic [DATA_W-1:0] idata_n, ddata_n;

  assign any_req  = ireq_i | dreq_i;
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  assign finish   = in_grant && (bus_ack_i || (cnt == TMO_LAST));

`ifdef MEM_ARB_RR_EN
  // last_grant = 1 means the data port was served most recently
  logic last_grant;
  assign pick_d = dreq_i & (~ireq_i | ~last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_grant <= pick_d;
    end
  end
`else
  assign pick_d = dreq_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= in_grant ? cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:             if (any_req) state_n = pick_d ? GRANT_D : GRANT_I;
      GRANT_I, GRANT_D: if (finish) state_n = DONE;
      DONE:             state_n = IDLE;
      default:          state_n = IDLE;
    endcase
  end

  always_comb begin
    bus_req_n   = bus_req_o;
    bus_we_n    = bus_we_o;
    bus_addr_n  = bus_addr_o;
    bus_wdata_n = bus_wdata_o;
    bus_sel_n   = bus_sel_o;
    iack_n      = 1'b0;
    ierr_n      = 1'b0;
    dack_n      = 1'b0;
    derr_n      = 1'b0;
    idata_n     = idata_o;
    ddata_n     = ddata_o;
    case (state)
      IDLE: begin
        if (any_req) begin
          bus_req_n = 1'b1;
          if (pick_d) begin
            bus_we_n    = dwe_i;
            bus_addr_n  = daddr_i;
            bus_wdata_n = dwdata_i;
            bus_sel_n   = dsel_i;
          end else begin
            bus_we_n    = 1'b0;
            bus_addr_n  = iaddr_i;
            bus_wdata_n = '0;
            bus_sel_n   = '1;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        // An ack on the final counted cycle still completes normally
        if (finish) begin
          bus_req_n   = 1'b0;
          bus_we_n    = 1'b0;
          bus_addr_n  = '0;
          bus_wdata_n = '0;
          bus_sel_n   = '0;
          if (state == GRANT_I) begin
            iack_n  = 1'b1;
            ierr_n  = ~bus_ack_i;
            idata_n = bus_ack_i ? bus_rdata_i : '0;
          end else begin
            dack_n  = 1'b1;
            derr_n  = ~bus_ack_i;
            ddata_n = (bus_ack_i && !bus_we_o) ? bus_rdata_i : '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_sel_o   <= '0;
      iack_o      <= 1'b0;
      ierr_o      <= 1'b0;
      dack_o      <= 1'b0;
      derr_o      <= 1'b0;
      idata_o     <= '0;
      ddata_o     <= '0;
    end else begin
      bus_req_o   <= bus_req_n;
      bus_we_o    <= bus_we_n;
      bus_addr_o  <= bus_addr_n;
      bus_wdata_o <= bus_wdata_n;
      bus_sel_o   <= bus_sel_n;
      iack_o      <= iack_n;
      ierr_o      <= ierr_n;
      dack_o      <= dack_n;
      derr_o      <= derr_n;
      idata_o     <= idata_n;
      ddata_o     <= ddata_n;
    end
  end

  assign stallreq_if_o  = ~rst & ireq_i & ~iack_o;
  assign stallreq_mem_o = ~rst & dreq_i & ~dack_o;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter that shares one external memory bus between the instruction-fetch port and the data port of the memory-access stage.
- Sequences each transfer with a registered grant FSM, a bus-side req/ack handshake and a timeout watchdog.
- Returns read data and a completion pulse to the winning requester.
- Raises stall requests to the pipeline controller while either requester is waiting.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width (byte-select width is DATA_W/8)
TIMEOUT, 16, maximum bus cycles to wait for bus_ack_i before aborting; legal range 2..255

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ireq_i  in  1  instruction read request, level, held until iack_o
iaddr_i  in  ADDR_W  instruction address
iack_o  out  1  one-cycle completion pulse to instruction port
idata_o  out  DATA_W  instruction read data, valid with iack_o
ierr_o  out  1  instruction transfer timed out, valid with iack_o
dreq_i  in  1  data request, level, held until dack_o
dwe_i  in  1  1 = write, 0 = read
daddr_i  in  ADDR_W  data address
dwdata_i  in  DATA_W  write data
dsel_i  in  DATA_W/8  byte selects
dack_o  out  1  one-cycle completion pulse to data port
ddata_o  out  DATA_W  data read data, valid with dack_o
derr_o  out  1  data transfer timed out, valid with dack_o
bus_req_o  out  1  bus cycle active
bus_we_o  out  1  bus write enable
bus_addr_o  out  ADDR_W  bus address
bus_wdata_o  out  DATA_W  bus write data
bus_sel_o  out  DATA_W/8  bus byte selects
bus_ack_i  in  1  bus completion, one cycle
bus_rdata_i  in  DATA_W  bus read data, valid with bus_ack_i
stallreq_if_o  out  1  stall request for fetch stage
stallreq_mem_o  out  1  stall request for memory stage

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. While rst = 1, all outputs are zero at the next edge, the FSM goes to IDLE and the timeout counter clears.
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE, with a request present:
  - Select a winner and register the bus_* fields from that requester.
  - Move to GRANT_x.
  - Without RR: dreq_i has priority over ireq_i.
- GRANT_x:
  - bus_req_o = 1 and bus fields are held stable.
  - Counter increments each cycle.
- GRANT_x with bus_ack_i = 1:
  - Latch bus_rdata_i into x data output (writes latch 0).
  - Set x_ack_o = 1 and x_err_o = 0 for the next cycle, drop bus_req_o, go to DONE.
- GRANT_x with counter = TIMEOUT-1 and no ack:
  - Abort: bus_req_o drops, x_ack_o = 1, x_err_o = 1, x data = 0, go to DONE.
- DONE: ack/err held for exactly this one cycle, then go to IDLE.
  - The requester deasserts its req in the cycle after it sees the ack.
  - A request still high in IDLE after DONE is treated as a new transfer.
- Latency: request seen at edge 0 → bus_req_o in cycle 1 → bus_ack_i in cycle N (N ≥ 1) → x_ack_o in cycle N+1. Back-to-back transfers to the same port take a minimum of 4 cycles.
- bus_ack_i in IDLE or DONE is ignored.
- Requester inputs may change during GRANT; the bus fields stay latched.
- Stall requests (combinational):
  - stallreq_if_o = ireq_i & ~iack_o
  - stallreq_mem_o = dreq_i & ~dack_o
  - Both are forced to 0 during rst.
- Idle outputs: idata_o/ddata_o hold their last value between acks. bus_* fields are 0 whenever bus_req_o = 0.
- Reset mid-transfer aborts the transfer:
  - No ack is issued to the requester.
  - bus_req_o = 0 at the next edge.
  - A late bus_ack_i is ignored.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. A last_grant register resets to "instruction", so the data port wins the first tie. On a tie in IDLE, the port not served last wins. last_grant updates when a transfer enters GRANT_x.
- Undefined: fixed data-port priority and no last_grant register.

Test Plan:
- Instruction read: ireq_i = 1, iaddr_i = 0x00000100; bus acks 2 cycles after bus_req_o rises with rdata 0x3C010001 → bus_addr_o = 0x100, iack_o pulses once, idata_o = 0x3C010001, ierr_o = 0, stallreq_if_o falls with iack_o.
- Data write: dreq_i = 1, dwe_i = 1, daddr_i = 0x2000, dwdata_i = 0xDEADBEEF, dsel_i = 0xF → bus_we_o = 1 with those values held until bus_ack_i, then dack_o pulses once.
- Simultaneous requests, both held for 2 transfers, ack latency 1:
  - Without RR: data granted first, then instruction.
  - With RR: data first, instruction second, and a third tie goes to data.
- Timeout: dreq_i = 1 and bus never acks → bus_req_o high for exactly 16 cycles, then dack_o = 1, derr_o = 1, ddata_o = 0, FSM back in IDLE.
- Reset mid-transfer: assert rst in the second GRANT_I cycle, then bus_ack_i the cycle after → no iack_o, bus_req_o = 0, all outputs 0, next ireq_i serviced normally.
- Stray ack: bus_ack_i pulsed in IDLE with rdata 0x12345678 → no ack outputs and data outputs unchanged.
